// File: rtl/nt_response_misr_if.sv
// rtl/nt_response_misr_if.sv - stimulus/result bundle between a node-response source and the MISR stage
// Ports (as seen by the slave/MISR side):
//   start     in   begin a compaction window
//   node_in   in   node response bit
//   node_vld  in   node_in carries a valid sample this cycle
//   golden    in   expected signature, sampled with the final sample
//   busy      out  window in progress
//   done      out  one-cycle pulse: sig/mismatch ready
//   sig       out  last completed signature
//   mismatch  out  last signature differed from golden
//   cnt       out  valid samples absorbed in the current window
interface nt_response_misr_if #(
    parameter int W  = 16,
    parameter int CW = 10
);
    logic          start;
    logic          node_in;
    logic          node_vld;
    logic [W-1:0]  golden;
    logic          busy;
    logic          done;
    logic [W-1:0]  sig;
    logic          mismatch;
    logic [CW-1:0] cnt;

    modport master (
        output start, node_in, node_vld, golden,
        input  busy, done, sig, mismatch, cnt
    );

    modport slave (
        input  start, node_in, node_vld, golden,
        output busy, done, sig, mismatch, cnt
    );
endinterface

// File: rtl/nt_response_misr.sv
// rtl/nt_response_misr.sv - MISR compaction of a 1-bit node response with golden-signature compare
// Ports:
//   I1470  in   clock, all state changes on the rising edge
//   I1477  in   synchronous active-high reset
//   bus    slave side of nt_response_misr_if (start/node_in/node_vld/golden in,
//          busy/done/sig/mismatch/cnt out, all outputs registered)
module nt_response_misr #(
    parameter int           W    = 16,
    parameter logic [W-1:0] POLY = 16'h1021,
    parameter logic [W-1:0] SEED = 16'h0000,
    parameter int           NCYC = 1000,
    parameter int           CW   = 10
) (
    input  logic               I1470,
    input  logic               I1477,
    nt_response_misr_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  misr_q;
    logic [W-1:0]  misr_d;
    logic [W-1:0]  sig_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          busy_q;
    logic          done_q;
    logic          mismatch_q;
    logic          fb;
    logic          last_sample;

    // Galois-form MISR step: the outgoing MSB mixed with the new sample decides
    // whether the tap polynomial is folded into the shifted register.
    always_comb begin
        fb          = misr_q[W-1] ^ bus.node_in;
        misr_d      = {misr_q[W-2:0], 1'b0} ^ (fb ? POLY : '0);
        cnt_d       = cnt_q + CW'(1);
        last_sample = bus.node_vld && (cnt_q == CW'(NCYC - 1));
    end

    always_ff @(posedge I1470) begin
        if (I1477) begin
            state_q    <= ST_IDLE;
            misr_q     <= SEED;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sig_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q    <= ST_RUN;
                        busy_q     <= 1'b1;
                        misr_q     <= SEED;
                        cnt_q      <= '0;
                        mismatch_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.node_vld) begin
                        misr_q <= misr_d;
                        cnt_q  <= cnt_d;
                    end
                    // Verdict is captured on the final-sample edge so golden only
                    // needs to be valid in that cycle.
                    if (last_sample) begin
                        state_q    <= ST_DONE;
                        busy_q     <= 1'b0;
                        sig_q      <= misr_d;
                        mismatch_q <= (misr_d != bus.golden);
                    end
                end
                ST_DONE: begin
                    // done is registered on the way out of DONE, so it appears one
                    // cycle after the final-sample edge; start here is dropped.
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sig      = sig_q;
    assign bus.mismatch = mismatch_q;
    assign bus.cnt      = cnt_q;

endmodule

// File: tb/tb_nt_response_misr.sv
// tb/tb_nt_response_misr.sv - self-checking bench for nt_response_misr
module tb_nt_response_misr;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [16:0] sb4[$];
    logic [16:0] sbd[$];

    nt_response_misr_if #(.W(16), .CW(10)) if4 ();
    nt_response_misr_if #(.W(16), .CW(1))  if1 ();
    nt_response_misr_if #(.W(16), .CW(10)) ifd ();

    nt_response_misr #(.W(16), .POLY(16'h1021), .SEED(16'h0000), .NCYC(4), .CW(10))
        u_dut4 (.I1470(clk), .I1477(rst), .bus(if4));
    nt_response_misr #(.W(16), .POLY(16'h1021), .SEED(16'h0000), .NCYC(1), .CW(1))
        u_dut1 (.I1470(clk), .I1477(rst), .bus(if1));
    nt_response_misr u_dutd (.I1470(clk), .I1477(rst), .bus(ifd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] m, input logic b);
        logic fbk;
        fbk = m[15] ^ b;
        return {m[14:0], 1'b0} ^ (fbk ? 16'h1021 : 16'h0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pops: every done pulse must match the oldest pushed window result.
    always @(negedge clk) begin
        if (if4.done === 1'b1) begin
            n_cmp++;
            if (sb4.size() == 0) begin
                n_err++;
                $display("FAIL sb4_unexpected_done: got done=1 sig=%h, required no done", if4.sig);
            end else begin
                logic [16:0] e;
                e = sb4.pop_front();
                if ({if4.sig, if4.mismatch} !== e) begin
                    n_err++;
                    $display("FAIL sb4_result: got sig=%h mm=%b, required sig=%h mm=%b",
                             if4.sig, if4.mismatch, e[16:1], e[0]);
                end
            end
        end
        if (ifd.done === 1'b1) begin
            n_cmp++;
            if (sbd.size() == 0) begin
                n_err++;
                $display("FAIL sbd_unexpected_done: got done=1 sig=%h, required no done", ifd.sig);
            end else begin
                logic [16:0] e;
                e = sbd.pop_front();
                if ({ifd.sig, ifd.mismatch} !== e) begin
                    n_err++;
                    $display("FAIL sbd_result: got sig=%h mm=%b, required sig=%h mm=%b",
                             ifd.sig, ifd.mismatch, e[16:1], e[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // One NCYC=4 window: vld/din/stm are per-cycle masks (bit i = cycle i after start).
    task automatic run4(input logic [6:0] vld, input logic [6:0] din, input int n,
                        input logic [15:0] gold, input logic [6:0] stm, input bit start_in_done);
        logic [15:0] m;
        int          c;
        m = 16'h0000;
        c = 0;
        for (int i = 0; i < n; i++)
            if (vld[i]) m = step(m, din[i]);
        sb4.push_back({m, m != gold});
        if4.golden   = gold;
        if4.node_vld = 1'b1;
        if4.node_in  = 1'b1;
        if4.start    = 1'b1;
        tick();
        if4.start = 1'b0;
        chk("run4_busy_after_start", 32'(if4.busy), 32'd1);
        chk("run4_cnt_after_start", 32'(if4.cnt), 32'd0);
        chk("run4_mm_cleared", 32'(if4.mismatch), 32'd0);
        for (int i = 0; i < n; i++) begin
            if4.node_vld = vld[i];
            if4.node_in  = din[i];
            if4.start    = stm[i];
            tick();
            if (vld[i]) c++;
            chk($sformatf("run4_cnt_%0d", i), 32'(if4.cnt), 32'(c));
            if (i < n - 1) chk($sformatf("run4_busy_%0d", i), 32'(if4.busy), 32'd1);
        end
        if4.node_vld = 1'b0;
        if4.start    = start_in_done;
        chk("run4_busy_in_done", 32'(if4.busy), 32'd0);
        chk("run4_done_early", 32'(if4.done), 32'd0);
        chk("run4_sig_ready", 32'(if4.sig), 32'(m));
        tick();
        if4.start = 1'b0;
        chk("run4_done_pulse", 32'(if4.done), 32'd1);
        chk("run4_no_restart", 32'(if4.busy), 32'd0);
        chk("run4_mismatch", 32'(if4.mismatch), 32'(m != gold));
        tick();
        chk("run4_done_one_cycle", 32'(if4.done), 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if4.start = 1'b1; if4.node_vld = 1'b1; if4.node_in = 1'b1; if4.golden = '0;
        end
        if1.start = 1'b1; if1.node_vld = 1'b1; if1.node_in = 1'b1; if1.golden = '0;
        ifd.start = 1'b1; ifd.node_vld = 1'b1; ifd.node_in = 1'b1; ifd.golden = '0;
        tick();
        tick();
        chk("reset_busy", 32'(if4.busy), 32'd0);
        chk("reset_done", 32'(if4.done), 32'd0);
        chk("reset_mismatch", 32'(if4.mismatch), 32'd0);
        chk("reset_sig", 32'(if4.sig), 32'd0);
        chk("reset_cnt", 32'(if4.cnt), 32'd0);
        chk("reset_busy_d", 32'(ifd.busy), 32'd0);
        chk("reset_cnt_1", 32'(if1.cnt), 32'd0);
        if4.start = 1'b0; if4.node_vld = 1'b0;
        if1.start = 1'b0; if1.node_vld = 1'b0;
        ifd.start = 1'b0; ifd.node_vld = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_ignores_vld", 32'(if4.cnt), 32'd0);
    endtask

    task automatic test_basic();
        run4(7'b0001111, 7'b0000001, 4, 16'h8108, 7'b0, 1'b0);
        chk("basic_sig", 32'(if4.sig), 32'h8108);
    endtask

    task automatic test_mismatch_hold();
        run4(7'b0001111, 7'b0000001, 4, 16'h8109, 7'b0, 1'b0);
        for (int k = 0; k < 3; k++) tick();
        chk("mm_held", 32'(if4.mismatch), 32'd1);
        chk("sig_held", 32'(if4.sig), 32'h8108);
    endtask

    task automatic test_gaps();
        run4(7'b1011001, 7'b0100111, 7, 16'h8108, 7'b0, 1'b0);
        chk("gaps_sig", 32'(if4.sig), 32'h8108);
    endtask

    task automatic test_start_ignored();
        run4(7'b0001111, 7'b0000001, 4, 16'h8109, 7'b0000110, 1'b1);
        chk("start_ign_sig", 32'(if4.sig), 32'h8108);
        // done cycle is IDLE: a start here opens a new window and clears mismatch
        run4(7'b0001111, 7'b0000011, 4, 16'h0000, 7'b0, 1'b0);
    endtask

    task automatic test_reset_mid_window();
        if4.start = 1'b1;
        tick();
        if4.start    = 1'b0;
        if4.node_vld = 1'b1;
        if4.node_in  = 1'b1;
        tick();
        tick();
        chk("mid_cnt2", 32'(if4.cnt), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if4.node_vld = 1'b0;
        chk("mid_rst_busy", 32'(if4.busy), 32'd0);
        chk("mid_rst_cnt", 32'(if4.cnt), 32'd0);
        chk("mid_rst_sig", 32'(if4.sig), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_rst_no_done", 32'(if4.done), 32'd0);
        end
        run4(7'b0001111, 7'b0000001, 4, 16'h8108, 7'b0, 1'b0);
        chk("mid_rst_resig", 32'(if4.sig), 32'h8108);
    endtask

    task automatic test_ncyc1();
        if1.golden   = 16'h1021;
        if1.start    = 1'b1;
        if1.node_vld = 1'b1;
        if1.node_in  = 1'b1;
        tick();
        if1.start = 1'b0;
        chk("n1_start_cnt", 32'(if1.cnt), 32'd0);
        tick();
        if1.node_vld = 1'b0;
        chk("n1_cnt", 32'(if1.cnt), 32'd1);
        chk("n1_busy", 32'(if1.busy), 32'd0);
        tick();
        chk("n1_done", 32'(if1.done), 32'd1);
        chk("n1_sig", 32'(if1.sig), 32'h1021);
        chk("n1_mm", 32'(if1.mismatch), 32'd0);
    endtask

    task automatic test_random_default();
        logic [15:0] m;
        logic        rv[$];
        logic        rd[$];
        int          c;
        bit          seen;
        m = 16'h0000;
        c = 0;
        while (c < 1000) begin
            logic v;
            logic d;
            v = ($urandom_range(0, 3) != 0);
            d = 1'($urandom_range(0, 1));
            rv.push_back(v);
            rd.push_back(d);
            if (v) begin
                m = step(m, d);
                c++;
            end
        end
        sbd.push_back({m, 1'b0});
        ifd.golden = m;
        ifd.start  = 1'b1;
        tick();
        ifd.start = 1'b0;
        c = 0;
        for (int i = 0; i < rv.size(); i++) begin
            ifd.node_vld = rv[i];
            ifd.node_in  = rd[i];
            tick();
            if (rv[i]) c++;
        end
        ifd.node_vld = 1'b0;
        chk("rand_cnt", 32'(ifd.cnt), 32'(c));
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            tick();
            if (ifd.done === 1'b1) seen = 1'b1;
        end
        chk("rand_done_seen", 32'(seen), 32'd1);
        chk("rand_sig", 32'(ifd.sig), 32'(m));
        chk("rand_mm", 32'(ifd.mismatch), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_mismatch_hold();
        test_gaps();
        test_start_ignored();
        test_reset_mid_window();
        test_ncyc1();
        test_random_default();
        tick();
        chk("sb4_drained", 32'(sb4.size()), 32'd0);
        chk("sbd_drained", 32'(sbd.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
